bus_fifo_periph: RTL and testbench
==================================

# bus_fifo_periph

Memory-mapped FIFO peripheral that acts as a responder on the RV32I core's data bus (`busWe`/`busAddr`/`busWData`/`Byte_Enable` in, `busRData` out). The core pushes words by storing to a data register and pops them by loading from another. The block buffers up to `DEPTH` words and exposes control and status registers. It sits behind the top-level address decoder, which drives `busSel`. The core completes one bus access per cycle, and a load's address and control are held for exactly one cycle.

## Interface
- `DEPTH`, default 8: FIFO depth in words. Must be a power of 2 in the range 2..128.
- `clk`  in  1: clock. All state updates on the rising edge.
- `reset`  in  1: synchronous, active-low reset.
- `busSel`  in  1: decoder select for this peripheral.
- `busWe`  in  1: 1 = store, 0 = load.
- `busAddr`  in  32: byte address. Only bits [3:2] are decoded.
- `busWData`  in  32: store data.
- `Byte_Enable`  in  4: store byte lanes.
- `busRData`  out  32: load data. Combinational.
- `fifoEmpty`  out  1: count == 0.
- `fifoFull`  out  1: count == DEPTH.

## Operation
- Register map, selected by `busAddr[3:2]`:
  - 0x0 `CTRL` (R/W)
    - bit0 `EN`. Resets to 0.
    - bit1 `CLR`. Write-only, self-clearing, reads 0.
  - 0x4 `STATUS` (RO, with the write-1-to-clear exception under Configuration)
    - bit0 empty, bit1 full.
    - bits[15:8] count, zero-extended.
  - 0x8 `TXDATA` (WO, reads 0)
  - 0xC `RXDATA` (RO)
- All accesses require `busSel=1`. When `busSel=0`: no state change, and `busRData=0`.
- **CTRL write**
  - Only the lane-0 bits are used, and only if `Byte_Enable[0]=1`.
  - `EN` is loaded from `busWData[0]`.
  - If `busWData[1]=1` (`CLR`): read pointer, write pointer and count go to 0. Stored contents are don't-care.
- **Push** (store to `TXDATA` with `EN=1`, `Byte_Enable!=0`, not full)
  - Writes `busWData` with disabled lanes forced to 0.
  - Write pointer and count advance.
- **Pop** (load from `RXDATA` with `EN=1`, not empty)
  - `busRData` = head word in the same cycle.
  - Read pointer advances and count decrements at the closing edge.
- **Load from `RXDATA` when empty or `EN=0`:** returns the head entry if count>0, otherwise 0. No pointer change.
- **Dropped accesses:**
  - Push when full is dropped. Contents are unchanged.
  - Store to `TXDATA` with `EN=0` is dropped.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. Count is `$clog2(DEPTH)+1` bits.
- Push and pop cannot coincide because there is a single bus access per cycle.

## Timing
- **Reset** (`reset=0` at an edge):
  - Pointers, count and `EN` go to 0 (plus error flags when enabled).
  - Outputs: `fifoEmpty=1`, `fifoFull=0`. `busRData` is then 0 for `RXDATA`; for other registers it reflects the reset state.
  - Reset has priority over any concurrent bus access. A push in the reset cycle is lost.
- **Write latency:** a store takes effect at the closing edge of its cycle. `STATUS`, `fifoEmpty` and `fifoFull` reflect it from the next cycle.
- **Read latency:** zero cycles, since `busRData` is combinational on `busAddr`/`busSel`. A pop's side effect is visible from the next cycle.
- **Back-to-back accesses:**
  - A push followed immediately by a pop returns the pushed word.
  - DEPTH pushes followed by one more push leaves `full=1` and count=DEPTH.

## Configuration
- `BUS_FIFO_ERR_EN` defined:
  - `STATUS[2]` = sticky overflow, set by a push attempted while full with `EN=1`.
  - `STATUS[3]` = sticky underflow, set by a `RXDATA` load while empty with `EN=1`.
  - Both are cleared by a `STATUS` store with a 1 in the matching bit (lane 0 enabled), by `CLR`, or by reset.
  - If set and clear occur in the same cycle, set wins.
- Not defined: `STATUS[3:2]` read 0, no flag flops, and stores to `STATUS` are ignored.

## Structure
- Package `bus_fifo_pkg`:
  - Register offset constants: `FIFO_CTRL`=2'd0, `FIFO_STATUS`=2'd1, `FIFO_TXDATA`=2'd2, `FIFO_RXDATA`=2'd3.
  - Bit-index localparams for the `CTRL` and `STATUS` fields.
- Sub-module `fifo_core`:
  - Circular buffer with `push`, `pop`, `clr`, `wdata`, `rdata`, `count`, `empty`, `full`.
  - Parameterised by `DEPTH`.
- Top level: address decode, the `EN` register, the optional error flags, and the `busRData` mux.

## Test plan
- Reset, then read `STATUS` → 0x0000_0001. Read `CTRL` → 0.
- With `EN=0`: store 0xDEADBEEF to `TXDATA` → `STATUS` still 0x0000_0001. Then write `CTRL`=1 and store 0xDEADBEEF → `STATUS`=0x0000_0100. Load `RXDATA` → 0xDEADBEEF, and next `STATUS`=0x0000_0001.
- Store 0x11223344 to `TXDATA` with `Byte_Enable`=4'b0101, then load → 0x00220044.
- With DEPTH=8, push 1..8 → `fifoFull=1`, `STATUS`=0x0000_0802. Push 9 → dropped. Pop ×8 → 1..8 in order (wrap exercised by a second fill from pointer 5). Next load returns 0.
- Push 3 words, write `CTRL`=0x3 → count 0, `fifoEmpty=1`. Reset asserted mid-fill → `EN`=0, count 0.
- With `BUS_FIFO_ERR_EN`: overflow push sets `STATUS[2]`. A load while empty sets `STATUS[3]`. Storing 0x4 to `STATUS` clears only `STATUS[2]`.

Source files
------------

// File: rtl/bus_fifo_pkg.sv
// ============================================================================
// Module      : bus_fifo_pkg
// Description : Register offsets and field bit positions for bus_fifo_periph.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bus_fifo_pkg;

  localparam logic [1:0] FIFO_CTRL   = 2'd0;
  localparam logic [1:0] FIFO_STATUS = 2'd1;
  localparam logic [1:0] FIFO_TXDATA = 2'd2;
  localparam logic [1:0] FIFO_RXDATA = 2'd3;

  localparam int c_CTRL_EN      = 0;
  localparam int c_CTRL_CLR     = 1;
  localparam int c_STATUS_EMPTY = 0;
  localparam int c_STATUS_FULL  = 1;
  localparam int c_STATUS_OVF   = 2;
  localparam int c_STATUS_UNF   = 3;
  localparam int c_STATUS_CNT_LSB = 8;

  // Expands per-byte enables into a 32-bit lane mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

`default_nettype wire

// File: rtl/bus_fifo_periph_if.sv
// ============================================================================
// Module      : bus_fifo_periph_if
// Description : Core data-bus responder interface plus FIFO status flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bus_fifo_periph_if;
  logic        busSel;
  logic        busWe;
  logic [31:0] busAddr;
  logic [31:0] busWData;
  logic [3:0]  Byte_Enable;
  logic [31:0] busRData;
  logic        fifoEmpty;
  logic        fifoFull;

  modport master (
    output busSel, busWe, busAddr, busWData, Byte_Enable,
    input  busRData, fifoEmpty, fifoFull
  );

  modport slave (
    input  busSel, busWe, busAddr, busWData, Byte_Enable,
    output busRData, fifoEmpty, fifoFull
  );
endinterface

`default_nettype wire

// File: rtl/bus_fifo_periph_fifo_core.sv
// ============================================================================
// Module      : fifo_core
// Description : Power-of-2 circular word buffer with push/pop/clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_core #(
  parameter int DEPTH = 8
) (
  input  wire logic                       clk,
  input  wire logic                       reset,
  input  wire logic                       push,
  input  wire logic                       pop,
  input  wire logic                       clr,
  input  wire logic [31:0]                wdata,
  output logic      [31:0]                rdata,
  output logic      [$clog2(DEPTH):0]     count,
  output logic                            empty,
  output logic                            full
);

  localparam int c_PW = $clog2(DEPTH);
  localparam int c_CW = c_PW + 1;
  localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

  logic [31:0]     r_mem [DEPTH];
  logic [c_PW-1:0] r_wptr;
  logic [c_PW-1:0] r_rptr;
  logic [c_CW-1:0] r_count;

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (push && !full) begin
      r_wptr  <= r_wptr + 1'b1;
      r_count <= r_count + 1'b1;
    end else if (pop && !empty) begin
      r_rptr  <= r_rptr + 1'b1;
      r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && !clr && push && !full) begin
      r_mem[r_wptr] <= wdata;
    end
  end

  assign rdata = r_mem[r_rptr];
  assign count = r_count;
  assign empty = (r_count == '0);
  assign full  = (r_count == c_FULL);

endmodule

`default_nettype wire

// File: rtl/bus_fifo_periph.sv
// ============================================================================
// Module      : bus_fifo_periph
// Description : Memory-mapped FIFO peripheral on the core data bus.
//               Define BUS_FIFO_ERR_EN for sticky overflow/underflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_fifo_periph
  import bus_fifo_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  wire logic              clk,
  input  wire logic              reset,
  bus_fifo_periph_if.slave       bus
);

  localparam int c_CW = $clog2(DEPTH) + 1;

  logic              r_en;
  logic [1:0]        w_reg;
  logic              w_rd;
  logic              w_wr;
  logic              w_ctrl_wr;
  logic              w_clr;
  logic              w_tx_wr;
  logic              w_push;
  logic              w_rx_rd;
  logic              w_pop;
  logic [31:0]       w_wdata;
  logic [31:0]       w_head;
  logic [c_CW-1:0]   w_count;
  logic              w_empty;
  logic              w_full;
  logic              w_ovf;
  logic              w_unf;
  logic              w_unused_ok;

  assign w_reg     = bus.busAddr[3:2];
  assign w_wr      = bus.busSel &  bus.busWe;
  assign w_rd      = bus.busSel & ~bus.busWe;
  assign w_ctrl_wr = w_wr & (w_reg == FIFO_CTRL) & bus.Byte_Enable[0];
  assign w_clr     = w_ctrl_wr & bus.busWData[c_CTRL_CLR];
  assign w_tx_wr   = w_wr & (w_reg == FIFO_TXDATA) & r_en & (bus.Byte_Enable != 4'b0000);
  assign w_push    = w_tx_wr & ~w_full;
  assign w_rx_rd   = w_rd & (w_reg == FIFO_RXDATA) & r_en;
  assign w_pop     = w_rx_rd & ~w_empty;
  assign w_wdata   = bus.busWData & lane_mask(bus.Byte_Enable);
  assign w_unused_ok = &{1'b0, bus.busAddr[31:4], bus.busAddr[1:0]};

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_en <= 1'b0;
    end else if (w_ctrl_wr) begin
      r_en <= bus.busWData[c_CTRL_EN];
    end
  end

  fifo_core #(
    .DEPTH (DEPTH)
  ) u_fifo_core (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .clr   (w_clr),
    .wdata (w_wdata),
    .rdata (w_head),
    .count (w_count),
    .empty (w_empty),
    .full  (w_full)
  );

`ifdef BUS_FIFO_ERR_EN
  logic r_ovf;
  logic r_unf;
  logic w_status_wr;

  assign w_status_wr = w_wr & (w_reg == FIFO_STATUS) & bus.Byte_Enable[0];

  // A set in the same cycle as a clear takes precedence.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_tx_wr && w_full) begin
        r_ovf <= 1'b1;
      end else if (w_clr || (w_status_wr && bus.busWData[c_STATUS_OVF])) begin
        r_ovf <= 1'b0;
      end
      if (w_rx_rd && w_empty) begin
        r_unf <= 1'b1;
      end else if (w_clr || (w_status_wr && bus.busWData[c_STATUS_UNF])) begin
        r_unf <= 1'b0;
      end
    end
  end

  assign w_ovf = r_ovf;
  assign w_unf = r_unf;
`else
  assign w_ovf = 1'b0;
  assign w_unf = 1'b0;
`endif

  always_comb begin
    bus.busRData = 32'h0;
    if (bus.busSel) begin
      case (w_reg)
        FIFO_CTRL:   bus.busRData = {31'h0, r_en};
        FIFO_STATUS: bus.busRData = {16'h0, 8'(w_count), 4'h0, w_unf, w_ovf, w_full, w_empty};
        FIFO_TXDATA: bus.busRData = 32'h0;
        FIFO_RXDATA: bus.busRData = w_empty ? 32'h0 : w_head;
        default:     bus.busRData = 32'h0;
      endcase
    end
  end

  assign bus.fifoEmpty = w_empty;
  assign bus.fifoFull  = w_full;

endmodule

`default_nettype wire

// File: tb/tb_bus_fifo_periph.sv
// ============================================================================
// Module      : tb_bus_fifo_periph
// Description : Self-checking bench for bus_fifo_periph with a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_fifo_periph;

  localparam int DEPTH = 8;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  bus_fifo_periph_if bif ();

  bus_fifo_periph #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a word queue plus the EN bit and sticky flags.
  logic [31:0] mq[$];
  logic        m_en;
  logic        m_ovf;
  logic        m_unf;

  task automatic model_reset();
    mq.delete();
    m_en  = 1'b0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s = 32'h0;
    s[0] = (mq.size() == 0);
    s[1] = (mq.size() == DEPTH);
`ifdef BUS_FIFO_ERR_EN
    s[2] = m_ovf;
    s[3] = m_unf;
`endif
    s[15:8] = 8'(mq.size());
    return s;
  endfunction

  task automatic model_access(input logic s, input logic w, input logic [1:0] a,
                              input logic [31:0] d, input logic [3:0] be,
                              output logic [31:0] ex);
    logic [31:0] m;
    ex = 32'h0;
    if (s) begin
      case (a)
        2'd0: ex = {31'h0, m_en};
        2'd1: ex = model_status();
        2'd2: ex = 32'h0;
        default: ex = (mq.size() > 0) ? mq[0] : 32'h0;
      endcase
      if (w) begin
        if (a == 2'd0 && be[0]) begin
          m_en = d[0];
          if (d[1]) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
          end
        end else if (a == 2'd1 && be[0]) begin
          if (d[2]) m_ovf = 1'b0;
          if (d[3]) m_unf = 1'b0;
        end else if (a == 2'd2 && m_en && be != 4'b0) begin
          if (mq.size() < DEPTH) begin
            m = 32'h0;
            for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = d[8*i +: 8];
            mq.push_back(m);
          end else begin
            m_ovf = 1'b1;
          end
        end
      end else if (a == 2'd3 && m_en) begin
        if (mq.size() > 0) void'(mq.pop_front());
        else m_unf = 1'b1;
      end
    end
  endtask

  task automatic txn(input logic s, input logic w, input logic [1:0] a,
                     input logic [31:0] d, input logic [3:0] be,
                     output logic [31:0] rd, output logic [31:0] ex);
    @(negedge clk);
    bif.busSel      = s;
    bif.busWe       = w;
    bif.busAddr     = {28'h0, a, 2'b00};
    bif.busWData    = d;
    bif.Byte_Enable = be;
    #1 rd = bif.busRData;
    model_access(s, w, a, d, be, ex);
    @(posedge clk);
    #1;
    bif.busSel = 1'b0;
    bif.busWe  = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] rd, ex;
    txn(1'b1, 1'b1, a, d, be, rd, ex);
  endtask

  task automatic rdr(input logic [1:0] a, output logic [31:0] rd, output logic [31:0] ex);
    txn(1'b1, 1'b0, a, 32'h0, 4'h0, rd, ex);
  endtask

  task automatic test_reset();
    logic [31:0] rd, ex;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
    rdr(2'd1, rd, ex);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL reset_status got %h exp %h", rd, 32'h1); end
    rdr(2'd0, rd, ex);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_ctrl got %h exp %h", rd, 32'h0); end
    rdr(2'd3, rd, ex);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_rx got %h exp %h", rd, 32'h0); end
    checks++; if (bif.fifoEmpty !== 1'b1 || bif.fifoFull !== 1'b0) begin
      errors++; $display("FAIL reset_flags got e=%b f=%b exp e=1 f=0", bif.fifoEmpty, bif.fifoFull);
    end
  endtask

  task automatic test_enable_gate();
    logic [31:0] rd, ex;
    wr(2'd2, 32'hDEADBEEF, 4'hF);
    rdr(2'd1, rd, ex);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL en0_drop got %h exp %h", rd, 32'h1); end
    wr(2'd0, 32'h1, 4'h1);
    wr(2'd2, 32'hDEADBEEF, 4'hF);
    rdr(2'd1, rd, ex);
    checks++; if (rd !== 32'h100) begin errors++; $display("FAIL en1_push got %h exp %h", rd, 32'h100); end
    rdr(2'd3, rd, ex);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL pop_data got %h exp %h", rd, 32'hDEADBEEF); end
    rdr(2'd1, rd, ex);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL pop_status got %h exp %h", rd, 32'h1); end
  endtask

  task automatic test_byte_enable();
    logic [31:0] rd, ex;
    wr(2'd2, 32'h11223344, 4'b0101);
    rdr(2'd3, rd, ex);
    checks++; if (rd !== 32'h00220044) begin errors++; $display("FAIL byte_lanes got %h exp %h", rd, 32'h00220044); end
  endtask

  task automatic test_full_wrap();
    logic [31:0] rd, ex;
    for (int i = 0; i < 5; i++) wr(2'd2, 32'h100 + i, 4'hF);
    for (int i = 0; i < 5; i++) rdr(2'd3, rd, ex);
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 1; i <= DEPTH; i++) wr(2'd2, i, 4'hF);
      rdr(2'd1, rd, ex);
      checks++; if (rd !== 32'h0802) begin errors++; $display("FAIL full_status got %h exp %h", rd, 32'h0802); end
      checks++; if (bif.fifoFull !== 1'b1) begin errors++; $display("FAIL full_flag got %b exp 1", bif.fifoFull); end
      wr(2'd2, 32'h9, 4'hF);
      rdr(2'd1, rd, ex);
      checks++; if (rd !== ex) begin errors++; $display("FAIL overflow_status got %h exp %h", rd, ex); end
      for (int i = 1; i <= DEPTH; i++) begin
        rdr(2'd3, rd, ex);
        checks++; if (rd !== 32'(i)) begin errors++; $display("FAIL drain_order got %h exp %h", rd, i); end
      end
      rdr(2'd3, rd, ex);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL drain_empty got %h exp 0", rd); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, ex;
    logic [31:0] v;
    for (int i = 0; i < 4; i++) begin
      v = $urandom;
      wr(2'd2, v, 4'hF);
      rdr(2'd3, rd, ex);
      checks++; if (rd !== v) begin errors++; $display("FAIL push_pop got %h exp %h", rd, v); end
    end
  endtask

  task automatic test_clear_and_reset();
    logic [31:0] rd, ex;
    for (int i = 0; i < 3; i++) wr(2'd2, $urandom, 4'hF);
    wr(2'd0, 32'h3, 4'h1);
    rdr(2'd1, rd, ex);
    checks++; if (rd !== 32'h1 || bif.fifoEmpty !== 1'b1) begin
      errors++; $display("FAIL clr_status got %h e=%b exp %h e=1", rd, bif.fifoEmpty, 32'h1);
    end
    rdr(2'd0, rd, ex);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL clr_keeps_en got %h exp %h", rd, 32'h1); end
    wr(2'd2, 32'hA, 4'hF);
    wr(2'd2, 32'hB, 4'hF);
    @(negedge clk);
    reset = 1'b0;
    bif.busSel = 1'b1; bif.busWe = 1'b1; bif.busAddr = 32'h8;
    bif.busWData = 32'hC; bif.Byte_Enable = 4'hF;
    @(posedge clk);
    #1 reset = 1'b1;
    bif.busSel = 1'b0; bif.busWe = 1'b0;
    model_reset();
    rdr(2'd0, rd, ex);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL midfill_ctrl got %h exp 0", rd); end
    rdr(2'd1, rd, ex);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL midfill_status got %h exp %h", rd, 32'h1); end
  endtask

  task automatic test_random();
    logic [31:0] rd, ex, d;
    logic        s, w;
    logic [1:0]  a;
    logic [3:0]  be;
    wr(2'd0, 32'h1, 4'h1);
    for (int n = 0; n < 400; n++) begin
      s  = ($urandom_range(0, 9) != 0);
      a  = 2'($urandom_range(0, 3));
      w  = ($urandom_range(0, 99) < ((a == 2'd2) ? 70 : 30));
      be = 4'($urandom);
      d  = $urandom;
      if (a == 2'd0) d[1:0] = ($urandom_range(0, 14) == 0) ? 2'b11 :
                              (($urandom_range(0, 7) == 0) ? 2'b00 : 2'b01);
      checks++; if (bif.fifoEmpty !== (mq.size() == 0) || bif.fifoFull !== (mq.size() == DEPTH)) begin
        errors++; $display("FAIL rand_flags got e=%b f=%b exp size %0d", bif.fifoEmpty, bif.fifoFull, mq.size());
      end
      txn(s, w, a, d, be, rd, ex);
      if (!w || !s) begin
        checks++; if (rd !== ex) begin errors++; $display("FAIL rand_read a=%0d s=%b got %h exp %h", a, s, rd, ex); end
      end
    end
  endtask

`ifdef BUS_FIFO_ERR_EN
  task automatic test_err_flags();
    logic [31:0] rd, ex;
    wr(2'd0, 32'h3, 4'h1);
    for (int i = 0; i < DEPTH + 1; i++) wr(2'd2, i, 4'hF);
    rdr(2'd1, rd, ex);
    checks++; if (rd[2] !== 1'b1 || rd !== ex) begin errors++; $display("FAIL ovf_set got %h exp %h", rd, ex); end
    for (int i = 0; i < DEPTH + 1; i++) rdr(2'd3, rd, ex);
    rdr(2'd1, rd, ex);
    checks++; if (rd[3:2] !== 2'b11 || rd !== ex) begin errors++; $display("FAIL unf_set got %h exp %h", rd, ex); end
    wr(2'd1, 32'h4, 4'h1);
    rdr(2'd1, rd, ex);
    checks++; if (rd[3:2] !== 2'b10 || rd !== ex) begin errors++; $display("FAIL ovf_w1c got %h exp %h", rd, ex); end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bif.busSel = 1'b0; bif.busWe = 1'b0; bif.busAddr = 32'h0;
    bif.busWData = 32'h0; bif.Byte_Enable = 4'h0;
    model_reset();
    test_reset();
    test_enable_gate();
    test_byte_enable();
    test_full_wrap();
    test_back_to_back();
    test_clear_and_reset();
    test_random();
`ifdef BUS_FIFO_ERR_EN
    test_err_flags();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
